// File: rtl/router_dst_collector_pkg.sv
// Shared types for the switch output-port collector.
//   DEF_ADDR_W / DEF_DATA_W : default address / data widths
//   IDLE_ADDR               : dst_addr value meaning "no beat on the wire"
//   beat_t                  : one buffered beat {addr, data} at default widths
//   coll_state_e            : collector control state (RUN / FLUSH)
package router_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  localparam logic [DEF_ADDR_W-1:0] IDLE_ADDR = '0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } beat_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } coll_state_e;

endpackage

// File: rtl/router_dst_collector_if.sv
// Bus between the switch output port, the collector and its downstream consumer.
//   dst_addr / dst_data : switch output, sampled every clk; dst_addr==0 means idle
//   out_valid / out_ready / out_addr / out_data : downstream beat handshake
// Handshake: a beat transfers on a posedge where out_valid && out_ready. While
// out_valid is high and out_ready low, out_addr/out_data hold their value. out_valid
// never waits on out_ready; out_ready may be driven freely by the consumer.
// Modports: master = switch + consumer side, slave = collector.
interface router_dst_collector_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0] dst_addr;
  logic [DATA_W-1:0] dst_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output dst_addr, dst_data, out_ready,
    input  out_valid, out_addr, out_data
  );

  modport slave (
    input  dst_addr, dst_data, out_ready,
    output out_valid, out_addr, out_data
  );

endinterface

// File: rtl/router_dst_collector_fifo.sv
// router_sync_fifo: synchronous first-word-fall-through FIFO.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : clears pointers and count; overrides push/pop that cycle
//   push, push_data : write request (ignored when full unless popping the same cycle)
//   pop          : read request (ignored when empty)
//   head         : entry at the read pointer (valid when !empty)
//   count        : occupancy 0..DEPTH; full/empty derive from it
module router_sync_fifo
  import router_pkg::*;
#(
  parameter type entry_t = beat_t,
  parameter int  DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign empty = (count == '0);
  assign full  = (count == (PTR_W+1)'(DEPTH));

  // A pop frees the slot in the same cycle, so a push into a full FIFO succeeds then.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end
  end

  // Storage carries no reset; head is only meaningful while !empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/router_dst_collector.sv
// router_dst_collector: sink end of one switch output port.
// Samples dst_addr/dst_data every clk, keeps beats addressed to cfg_port_addr,
// buffers them in a FWFT FIFO and presents them on a valid/ready handshake.
//   clk, reset_n   : clock, asynchronous active-low reset
//   bus (slave)    : dst_addr/dst_data in, out_valid/out_ready/out_addr/out_data
//   cfg_port_addr  : this port's address (0 disables capture)
//   cfg_flush      : discard buffered and in-flight beats
//   fifo_count     : occupancy, rx_cnt: matched beats, drop_cnt: overflow drops
//   dbg_state      : control state (RUN / FLUSH)
// Build option: ROUTER_DROP_CNT_EN defined implements drop_cnt; otherwise it reads 0.
module router_dst_collector
  import router_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  router_dst_collector_if.slave       bus,
  input  logic [ADDR_W-1:0]           cfg_port_addr,
  input  logic                        cfg_flush,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]            rx_cnt,
  output logic [CNT_W-1:0]            drop_cnt,
  output coll_state_e                 dbg_state
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } slot_t;

  coll_state_e state, state_nxt;
  logic        match;
  logic        flush_act;
  logic        stage_vld;
  slot_t       stage_beat;
  slot_t       head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        drop;

  assign match = (bus.dst_addr != ADDR_W'(IDLE_ADDR)) && (bus.dst_addr == cfg_port_addr);

  // Flush acts in the cycle cfg_flush is seen and throughout the FLUSH state.
  assign flush_act = cfg_flush || (state == FLUSH);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (cfg_flush) state_nxt = FLUSH;
      FLUSH:   state_nxt = cfg_flush ? FLUSH : RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign dbg_state = state;

  // ---------------- match stage register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_vld  <= 1'b0;
      stage_beat <= '0;
    end else if (flush_act) begin
      stage_vld  <= 1'b0;
      stage_beat <= '0;
    end else begin
      stage_vld <= match;
      if (match) stage_beat <= '{addr: bus.dst_addr, data: bus.dst_data};
    end
  end

  // ---------------- buffer ----------------
  router_sync_fifo #(
    .entry_t (slot_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush_act),
    .push      (stage_vld),
    .push_data (stage_beat),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // out_valid is masked while flushing so no beat is handed over that the
  // flush is about to discard.
  assign bus.out_valid = !fifo_empty && !flush_act;
  assign bus.out_addr  = bus.out_valid ? head.addr : '0;
  assign bus.out_data  = bus.out_valid ? head.data : '0;
  assign pop           = bus.out_valid && bus.out_ready;

  assign drop = stage_vld && fifo_full && !pop && !flush_act;

  // ---------------- counters ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_cnt <= '0;
    end else if (match && !flush_act && (rx_cnt != {CNT_W{1'b1}})) begin
      rx_cnt <= rx_cnt + CNT_W'(1);
    end
  end

`ifdef ROUTER_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
`else
  assign drop_cnt = '0;
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_router_dst_collector.sv
module tb_router_dst_collector;
  import router_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  router_dst_collector_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [ADDR_W-1:0]          cfg_port_addr = '0;
  logic                       cfg_flush = 1'b0;
  logic [$clog2(DEPTH):0]     fifo_count;
  logic [CNT_W-1:0]           rx_cnt;
  logic [CNT_W-1:0]           drop_cnt;
  coll_state_e                dbg_state;

  router_dst_collector #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .cfg_port_addr (cfg_port_addr),
    .cfg_flush     (cfg_flush),
    .fifo_count    (fifo_count),
    .rx_cnt        (rx_cnt),
    .drop_cnt      (drop_cnt),
    .dbg_state     (dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Behavioural view: a beat seen on the wire is matched, travels one cycle,
  // then enters a bounded queue of DEPTH beats unless the queue is full and
  // nothing leaves it that cycle. Flush empties everything in flight.
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int   m_cnt = 0;
  int   m_rx = 0;
  int   m_drop = 0;
  bit   m_pend = 0;
  logic [ADDR_W+DATA_W-1:0] m_pend_beat = '0;
  bit   m_flush_st = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_cnt = 0; m_rx = 0; m_drop = 0; m_pend = 0; m_flush_st = 0;
    end else begin
      bit flushing, matched, popped;
      flushing = cfg_flush || m_flush_st;
      matched  = (bus.dst_addr != 0) && (bus.dst_addr == cfg_port_addr);
      if (flushing) begin
        exp_q.delete();
        m_cnt  = 0;
        m_pend = 0;
      end else begin
        popped = (m_cnt > 0) && bus.out_ready;
        if (m_pend) begin
          if (m_cnt == DEPTH && !popped) begin
            if (m_drop < CNT_MAX) m_drop++;
          end else begin
            exp_q.push_back(m_pend_beat);
            m_cnt++;
          end
        end
        if (popped) m_cnt--;
        if (matched && m_rx < CNT_MAX) m_rx++;
        m_pend      = matched;
        m_pend_beat = {bus.dst_addr, bus.dst_data};
      end
      m_flush_st = cfg_flush;
    end
  end

  function automatic int exp_drop();
`ifdef ROUTER_DROP_CNT_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int delivered = 0;

  always @(negedge clk) begin
    bit exp_valid;
    exp_valid = (m_cnt != 0) && !(cfg_flush || m_flush_st);
    chk("fifo_count", fifo_count, m_cnt);
    chk("rx_cnt", rx_cnt, m_rx);
    chk("drop_cnt", drop_cnt, exp_drop());
    chk("out_valid", bus.out_valid, exp_valid);
    chk("state", dbg_state, m_flush_st);
    if (!bus.out_valid) begin
      chk("idle_out", {bus.out_addr, bus.out_data}, 0);
    end else if (bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {bus.out_addr, bus.out_data}, -1);
      end else begin
        chk("beat", {bus.out_addr, bus.out_data}, exp_q[0]);
        void'(exp_q.pop_front());
        delivered++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic beat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.dst_addr = a;
    bus.dst_data = d;
    tick();
    bus.dst_addr = '0;
  endtask

  // ---------------- stimulus ----------------
  int rx_before;
  int drop_ovf;

  initial begin
    bus.dst_addr  = 8'd3;
    bus.dst_data  = 16'h1234;
    bus.out_ready = 1'b1;
    cfg_port_addr = 8'd3;
`ifdef ROUTER_DROP_CNT_EN
    drop_ovf = 2;
`else
    drop_ovf = 0;
`endif

    // reset held with a matching beat on the wire
    repeat (5) tick();
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_count", fifo_count, 0);
    chk("reset_rx", rx_cnt, 0);
    reset_n = 1'b1;
    bus.dst_addr = '0;
    tick();

    // single beat, latency 2
    beat(8'd3, 16'hA5A5);
    tick();
    chk("lat2_valid", bus.out_valid, 1);
    chk("lat2_data", bus.out_data, 16'hA5A5);
    repeat (3) tick();
    chk("single_rx", rx_cnt, 1);

    // filter
    beat(8'd0, 16'h1111);
    beat(8'd2, 16'h2222);
    beat(8'd4, 16'h4444);
    repeat (3) tick();
    chk("filter_rx", rx_cnt, 1);

    // overflow
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) beat(8'd3, DATA_W'(i));
    repeat (2) tick();
    chk("ovf_count", fifo_count, 8);
    chk("ovf_drop", drop_cnt, drop_ovf);
    chk("ovf_rx", rx_cnt, 11);
    bus.out_ready = 1'b1;
    repeat (10) tick();

    // full with simultaneous pop
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) beat(8'd3, DATA_W'(16'h100 + i));
    repeat (2) tick();
    beat(8'd3, 16'h0109);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("fullpop_count", fifo_count, 8);
    chk("fullpop_drop", drop_cnt, drop_ovf);
    bus.out_ready = 1'b1;
    repeat (10) tick();

    // flush with a beat arriving in the same cycle
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) beat(8'd3, DATA_W'(16'h200 + i));
    repeat (2) tick();
    rx_before = m_rx;
    cfg_flush = 1'b1;
    beat(8'd3, 16'h02FF);
    cfg_flush = 1'b0;
    chk("flush_count", fifo_count, 0);
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_rx", rx_cnt, rx_before);
    tick();
    bus.out_ready = 1'b1;
    beat(8'd3, 16'h0042);
    tick();
    chk("post_flush_data", bus.out_data, 16'h0042);
    repeat (3) tick();

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2)      bus.dst_addr = '0;
      else if (r < 7) bus.dst_addr = cfg_port_addr;
      else            bus.dst_addr = ADDR_W'($urandom_range(1, 6));
      bus.dst_data  = DATA_W'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      cfg_flush     = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 2) begin
        case ($urandom_range(0, 2))
          0:       cfg_port_addr = 8'd0;
          1:       cfg_port_addr = 8'd3;
          default: cfg_port_addr = 8'd5;
        endcase
      end
      if (c == 400) reset_n = 1'b0;
      if (c == 402) reset_n = 1'b1;
      tick();
    end

    // drain with a bounded wait
    bus.dst_addr  = '0;
    cfg_flush     = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) tick();
    chk("drain_left", exp_q.size(), 0);
    chk("delivered_some", (delivered > 20), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
